// File: rtl/bali_pkg.sv
// Shared definitions for the bytecode core front end: fetch FSM states and
// the argument-count width reported by the decoder.
package bali_pkg;

  localparam int ARGC_W = 2;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_OP    = 3'd1,
    S_ARG1  = 3'd2,
    S_ARG2  = 3'd3,
    S_ISSUE = 3'd4
  } fetch_state_t;

  // The decoder reports 3 for unsupported opcodes; those are still consumed
  // as two-argument instructions so the PC stays aligned with the stream.
  function automatic logic [ARGC_W-1:0] eff_argc(input logic [ARGC_W-1:0] argc);
    return (argc == ARGC_W'(3)) ? ARGC_W'(2) : argc;
  endfunction

endpackage

// File: rtl/bytecode_fetch_if.sv
// Fetch-stage bus bundle: program memory port, decoder lookup, instruction
// hand-off to the executor, and the executor's redirect request.
interface bytecode_fetch_if #(
  parameter int ADDR_W = 16
);

  // program memory
  logic [ADDR_W-1:0]             mem_addr;
  logic [7:0]                    mem_rd_data;
  // decoder lookup
  logic [7:0]                    dec_opcode;
  logic [bali_pkg::ARGC_W-1:0]   dec_argc;
  // instruction hand-off
  logic                          instr_valid;
  logic                          instr_ready;
  logic [7:0]                    instr_opcode;
  logic [15:0]                   instr_arg;
  logic [ADDR_W-1:0]             instr_pc;
  logic                          instr_err;
  // redirect
  logic                          jump_en;
  logic [ADDR_W-1:0]             jump_target;

  // fetch stage side
  modport master (
    output mem_addr, dec_opcode,
    output instr_valid, instr_opcode, instr_arg, instr_pc, instr_err,
    input  mem_rd_data, dec_argc, instr_ready, jump_en, jump_target
  );

  // memory / decoder / executor side
  modport slave (
    input  mem_addr, dec_opcode,
    input  instr_valid, instr_opcode, instr_arg, instr_pc, instr_err,
    output mem_rd_data, dec_argc, instr_ready, jump_en, jump_target
  );

endinterface

// File: rtl/bytecode_fetch.sv
// Bytecode instruction fetch: reads the opcode byte, asks the decoder how many
// argument bytes follow, gathers them, and presents one assembled instruction
// to the executor. Owns the PC and honours executor redirects.
module bytecode_fetch
  import bali_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  bytecode_fetch_if.master bus
);

  fetch_state_t       state_reg, state_next;
  logic [ADDR_W-1:0]  pc_reg;
  logic [7:0]         opcode_reg;
  logic [7:0]         b1_reg;
  logic [ARGC_W-1:0]  argc_reg;
  logic               err_reg;

  logic [7:0]         instr_opcode_reg;
  logic [15:0]        instr_arg_reg;
  logic [ADDR_W-1:0]  instr_pc_reg;
  logic               instr_err_reg;

  logic [ARGC_W-1:0]  argc_eff;
  logic               handshake;
  logic               load_issue;
  logic [7:0]         issue_opcode;
  logic [15:0]        issue_arg;
  logic               issue_err;

  assign argc_eff  = eff_argc(bus.dec_argc);
  assign handshake = (state_reg == S_ISSUE) && bus.instr_ready;

  // The decoder sees the opcode straight from memory while it is being read,
  // and the latched copy for the rest of the instruction.
  assign bus.dec_opcode = (state_reg == S_OP) ? bus.mem_rd_data : opcode_reg;

  assign bus.instr_valid  = (state_reg == S_ISSUE);
  assign bus.instr_opcode = instr_opcode_reg;
  assign bus.instr_arg    = instr_arg_reg;
  assign bus.instr_pc     = instr_pc_reg;
  assign bus.instr_err    = instr_err_reg;

  // Next-state selection for the fetch sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH: state_next = S_OP;
      S_OP:    state_next = (argc_eff == '0) ? S_ISSUE : S_ARG1;
      S_ARG1:  state_next = (argc_reg >= ARGC_W'(2)) ? S_ARG2 : S_ISSUE;
      S_ARG2:  state_next = S_ISSUE;
      S_ISSUE: state_next = bus.instr_ready ? S_FETCH : S_ISSUE;
      default: state_next = S_FETCH;
    endcase
  end

  // Memory address: opcode at pc, then arguments at pc+1 / pc+2 (wrapping).
  // Outside the read states the address parks on pc so nothing moves while
  // an instruction waits for the executor.
  always_comb begin
    bus.mem_addr = pc_reg;
    case (state_reg)
      S_OP:    bus.mem_addr = pc_reg + ADDR_W'(1);
      S_ARG1:  bus.mem_addr = pc_reg + ADDR_W'(2);
      default: bus.mem_addr = pc_reg;
    endcase
  end

  // Assemble the outgoing instruction on the cycle its last byte arrives.
  always_comb begin
    load_issue   = 1'b0;
    issue_opcode = opcode_reg;
    issue_arg    = 16'h0000;
    issue_err    = err_reg;
    case (state_reg)
      S_OP: begin
        if (argc_eff == '0) begin
          load_issue   = 1'b1;
          issue_opcode = bus.mem_rd_data;
          issue_err    = 1'b0;
        end
      end
      S_ARG1: begin
        if (argc_reg < ARGC_W'(2)) begin
          load_issue = 1'b1;
          issue_arg  = {8'h00, bus.mem_rd_data};
        end
      end
      S_ARG2: begin
        load_issue = 1'b1;
        issue_arg  = {b1_reg, bus.mem_rd_data};
      end
      default: load_issue = 1'b0;
    endcase
  end

  // State, PC and instruction registers; reset beats redirect beats handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= S_FETCH;
      pc_reg           <= RESET_PC;
      opcode_reg       <= 8'h00;
      b1_reg           <= 8'h00;
      argc_reg         <= '0;
      err_reg          <= 1'b0;
      instr_opcode_reg <= 8'h00;
      instr_arg_reg    <= 16'h0000;
      instr_pc_reg     <= RESET_PC;
      instr_err_reg    <= 1'b0;
    end else if (bus.jump_en) begin
      // Whatever was in flight is dropped, including a pending hand-off.
      state_reg     <= S_FETCH;
      pc_reg        <= bus.jump_target;
      err_reg       <= 1'b0;
      instr_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_OP) begin
        opcode_reg <= bus.mem_rd_data;
        argc_reg   <= argc_eff;
        err_reg    <= (bus.dec_argc == ARGC_W'(3));
      end
      if (state_reg == S_ARG1) begin
        b1_reg <= bus.mem_rd_data;
      end
      if (load_issue) begin
        instr_opcode_reg <= issue_opcode;
        instr_arg_reg    <= issue_arg;
        instr_pc_reg     <= pc_reg;
        instr_err_reg    <= issue_err;
      end
      if (handshake) begin
        pc_reg        <= pc_reg + ADDR_W'(1) + ADDR_W'(argc_reg);
        instr_err_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bytecode_fetch.sv
// Self-checking bench for bytecode_fetch: table of single-instruction vectors,
// hand-written stall/redirect/reset sequences, a wrap-around instance, and a
// randomized run scored against an instruction-level reference model.
module tb_bytecode_fetch;
  import bali_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;

  bytecode_fetch_if #(.ADDR_W(16)) if0 ();
  bytecode_fetch_if #(.ADDR_W(16)) if1 ();

  bytecode_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut0 (.clk(clk), .rst(rst0), .bus(if0));
  bytecode_fetch #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut1 (.clk(clk), .rst(rst1), .bus(if1));

  // Byte-wide program memory with one-cycle registered read, shared by both instances.
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if0.mem_rd_data <= mem[if0.mem_addr];
    if1.mem_rd_data <= mem[if1.mem_addr];
  end

  // Decoder: argument byte count per opcode (0xFF stands in for an unsupported opcode).
  function automatic logic [1:0] dec_fn(input logic [7:0] op);
    if (op == 8'hFF) return 2'd3;
    if (op == 8'h10 || (op >= 8'h15 && op <= 8'h19) || (op >= 8'h36 && op <= 8'h3A) || op == 8'hBC)
      return 2'd1;
    if (op == 8'h11 || op == 8'h84 || (op >= 8'h99 && op <= 8'hA8))
      return 2'd2;
    return 2'd0;
  endfunction

  assign if0.dec_argc = dec_fn(if0.dec_opcode);
  assign if1.dec_argc = dec_fn(if1.dec_opcode);

  int vec_count  = 0;
  int fail_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_count++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid0(inout int cyc);
    while (!if0.instr_valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  // Reset dut0 and leave it at the first S_FETCH cycle with pc=0.
  task automatic reset0();
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2;
    int          lat;
    logic [15:0] arg;
    logic        err;
    logic [15:0] nxt;
  } vec_t;

  vec_t vecs [6];

  // Load one instruction at address 0, time it from reset, check it, accept it.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    mem[0] = v.b0; mem[1] = v.b1; mem[2] = v.b2;
    if0.instr_ready = 1'b0;
    reset0();
    check($sformatf("v%0d_fetch_addr", idx), 64'(if0.mem_addr), 64'h0);
    tick();
    cyc = 1;
    check($sformatf("v%0d_op_addr", idx), 64'(if0.mem_addr), 64'h1);
    wait_valid0(cyc);
    check($sformatf("v%0d_latency", idx), 64'(cyc), 64'(v.lat));
    check($sformatf("v%0d_instr", idx),
          {39'h0, if0.instr_valid, if0.instr_opcode, if0.instr_arg},
          {39'h0, 1'b1, v.b0, v.arg});
    check($sformatf("v%0d_pc_err", idx), {47'h0, if0.instr_err, if0.instr_pc}, {47'h0, v.err, 16'h0000});
    if0.instr_ready = 1'b1;
    tick();
    if0.instr_ready = 1'b0;
    check($sformatf("v%0d_next_addr", idx),
          {46'h0, if0.instr_valid, if0.instr_err, if0.mem_addr}, {46'h0, 1'b0, 1'b0, v.nxt});
  endtask

  // Instruction-level reference model state for the randomized run.
  logic [15:0] model_pc;
  logic [7:0]  m_op;
  logic [1:0]  m_n;
  logic [15:0] m_arg;
  logic [57:0] held, cur;
  logic        have_hold;
  int          n_hs;

  initial begin
    int cyc;
    rst0 = 1'b1; rst1 = 1'b1;
    if0.instr_ready = 1'b0; if0.jump_en = 1'b0; if0.jump_target = 16'h0;
    if1.instr_ready = 1'b0; if1.jump_en = 1'b0; if1.jump_target = 16'h0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    repeat (3) tick();

    // Reset state of both instances.
    check("rst0_outputs",
          {if0.instr_valid, if0.instr_err, if0.instr_opcode, if0.instr_arg, if0.instr_pc, if0.mem_addr},
          {1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0000});
    check("rst1_outputs",
          {if1.instr_valid, if1.instr_err, if1.instr_opcode, if1.instr_arg, if1.instr_pc, if1.mem_addr},
          {1'b0, 1'b0, 8'h00, 16'h0000, 16'hFFFF, 16'hFFFF});

    // Single-instruction vectors: bytes, latency, arg, err, next fetch address.
    vecs[0] = '{8'h60, 8'h00, 8'h00, 2, 16'h0000, 1'b0, 16'h0001};
    vecs[1] = '{8'h10, 8'h7F, 8'h00, 3, 16'h007F, 1'b0, 16'h0002};
    vecs[2] = '{8'hA7, 8'h00, 8'h05, 4, 16'h0005, 1'b0, 16'h0003};
    vecs[3] = '{8'h11, 8'h12, 8'h34, 4, 16'h1234, 1'b0, 16'h0003};
    vecs[4] = '{8'hFF, 8'hAB, 8'hCD, 4, 16'hABCD, 1'b1, 16'h0003};
    vecs[5] = '{8'h15, 8'h03, 8'h99, 3, 16'h0003, 1'b0, 16'h0002};
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Stall: executor holds ready low for five cycles in issue.
    mem[0] = 8'h10; mem[1] = 8'h7F;
    reset0();
    cyc = 0;
    wait_valid0(cyc);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall_hold_%0d", i),
            {if0.instr_valid, if0.instr_err, if0.instr_opcode, if0.instr_arg, if0.instr_pc, if0.mem_addr},
            {1'b1, 1'b0, 8'h10, 16'h007F, 16'h0000, 16'h0000});
    end
    if0.instr_ready = 1'b1;
    tick();
    if0.instr_ready = 1'b0;
    check("stall_next_addr", 64'(if0.mem_addr), 64'h2);

    // Redirect during argument fetch: the goto never issues.
    mem[0] = 8'hA7; mem[1] = 8'h00; mem[2] = 8'h05; mem[16'h40] = 8'h60;
    reset0();
    tick();
    tick();
    check("jump_arg1_addr", 64'(if0.mem_addr), 64'h2);
    if0.jump_en = 1'b1; if0.jump_target = 16'h0040;
    tick();
    if0.jump_en = 1'b0;
    check("jump_arg1_after", {47'h0, if0.instr_valid, if0.mem_addr}, {47'h0, 1'b0, 16'h0040});
    cyc = 0;
    wait_valid0(cyc);
    check("jump_arg1_target_instr", {40'h0, if0.instr_opcode, if0.instr_pc}, {40'h0, 8'h60, 16'h0040});

    // Redirect coinciding with a handshake: the jump wins.
    mem[0] = 8'h10; mem[1] = 8'h7F;
    reset0();
    cyc = 0;
    wait_valid0(cyc);
    if0.instr_ready = 1'b1; if0.jump_en = 1'b1; if0.jump_target = 16'h0040;
    tick();
    if0.instr_ready = 1'b0; if0.jump_en = 1'b0;
    check("jump_hs_after", {47'h0, if0.instr_valid, if0.mem_addr}, {47'h0, 1'b0, 16'h0040});

    // Unsupported opcode flag is dropped by a redirect.
    mem[0] = 8'hFF; mem[1] = 8'h01; mem[2] = 8'h02;
    reset0();
    cyc = 0;
    wait_valid0(cyc);
    check("err_set", 64'(if0.instr_err), 64'h1);
    if0.jump_en = 1'b1; if0.jump_target = 16'h0100;
    tick();
    if0.jump_en = 1'b0;
    check("err_cleared_by_jump", {47'h0, if0.instr_err, if0.mem_addr}, {47'h0, 1'b0, 16'h0100});

    // Randomized run against the instruction-level model.
    for (int i = 0; i < 65536; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      mem[i] = ($urandom_range(0, 15) == 0) ? 8'hFF : r;
    end
    reset0();
    model_pc = 16'h0000;
    have_hold = 1'b0;
    n_hs = 0;
    for (int c = 0; c < 4000; c++) begin
      cur = {if0.instr_valid, if0.instr_err, if0.instr_opcode, if0.instr_arg, if0.instr_pc, if0.mem_addr};
      if (have_hold) check("rand_hold", cur, held);
      if0.instr_ready = ($urandom_range(0, 3) != 0);
      if0.jump_en     = ($urandom_range(0, 40) == 0);
      if0.jump_target = 16'($urandom);
      if (if0.instr_valid && if0.instr_ready && !if0.jump_en) begin
        m_op = mem[model_pc];
        m_n  = dec_fn(m_op);
        if (m_n == 2'd0)      m_arg = 16'h0000;
        else if (m_n == 2'd1) m_arg = {8'h00, mem[16'(model_pc + 16'd1)]};
        else                  m_arg = {mem[16'(model_pc + 16'd1)], mem[16'(model_pc + 16'd2)]};
        check("rand_opcode", 64'(if0.instr_opcode), 64'(m_op));
        check("rand_arg",    64'(if0.instr_arg),    64'(m_arg));
        check("rand_pc",     64'(if0.instr_pc),     64'(model_pc));
        check("rand_err",    64'(if0.instr_err),    64'(m_n == 2'd3));
        model_pc = model_pc + 16'd1 + ((m_n == 2'd3) ? 16'd2 : 16'(m_n));
        n_hs++;
      end
      if (if0.jump_en) model_pc = if0.jump_target;
      have_hold = if0.instr_valid && !if0.instr_ready && !if0.jump_en;
      held = cur;
      tick();
    end
    if0.instr_ready = 1'b0; if0.jump_en = 1'b0;
    check("rand_progress", 64'(n_hs >= 200), 64'h1);

    // Wrap-around instance: bipush at 0xFFFF takes its argument from 0x0000.
    mem[16'hFFFF] = 8'h10; mem[0] = 8'h7F;
    mem[1] = 8'hA7; mem[2] = 8'h00; mem[3] = 8'h00;
    rst1 = 1'b0;
    check("wrap_fetch_addr", 64'(if1.mem_addr), 64'hFFFF);
    tick();
    check("wrap_arg_addr", 64'(if1.mem_addr), 64'h0000);
    cyc = 1;
    while (!if1.instr_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("wrap_latency", 64'(cyc), 64'h3);
    check("wrap_instr", {24'h0, if1.instr_opcode, if1.instr_arg, if1.instr_pc},
          {24'h0, 8'h10, 16'h007F, 16'hFFFF});
    if1.instr_ready = 1'b1;
    tick();
    if1.instr_ready = 1'b0;
    check("wrap_next_addr", 64'(if1.mem_addr), 64'h0001);
    tick();
    tick();
    check("wrap_arg1_addr", 64'(if1.mem_addr), 64'h0003);
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    check("midfetch_reset",
          {if1.instr_valid, if1.instr_opcode, if1.instr_pc, if1.mem_addr},
          {1'b0, 8'h00, 16'hFFFF, 16'hFFFF});

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
